// File: rtl/ladybird_mem_responder.sv
// Word-addressed memory responder with a 2-entry in-order request queue.
// Each head entry is granted LATENCY cycles after it reaches the head.
module ladybird_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic              req,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [XLEN-1:0]   wdata,
  output logic              ready,
  output logic              gnt,
  output logic [XLEN-1:0]   rdata,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = XLEN / 8;
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  logic [XLEN-1:0] r_mem [DEPTH];

  logic [XLEN-1:2] r_q_addr  [2];
  logic [SW-1:0]   r_q_wstrb [2];
  logic [XLEN-1:0] r_q_wdata [2];

  state_t     r_state;
  logic [1:0] r_occ;
  logic       r_head;
  logic [3:0] r_cnt;

  logic            w_accept;
  logic            w_tail;
  logic [1:0]      w_occ_nxt;
  logic [XLEN-1:2] w_h_addr;
  logic [SW-1:0]   w_h_wstrb;
  logic [XLEN-1:0] w_h_wdata;
  logic [AW-1:0]   w_idx;
  logic            w_oor;
  logic            w_wr;
  logic            w_unused_addr;

  assign w_unused_addr = ^addr[1:0];

  assign ready     = ~r_occ[1];
  assign w_accept  = req & ready;
  assign w_tail    = r_head ^ r_occ[0];
  assign gnt       = (r_state == S_WAIT) && (r_cnt == 4'd1);
  assign w_occ_nxt = r_occ + {1'b0, w_accept} - {1'b0, gnt};

  assign w_h_addr  = r_q_addr[r_head];
  assign w_h_wstrb = r_q_wstrb[r_head];
  assign w_h_wdata = r_q_wdata[r_head];
  assign w_idx     = w_h_addr[AW+1:2];
  assign w_oor     = |(w_h_addr >> AW);
  assign w_wr      = gnt & ~w_oor & (|w_h_wstrb) & nrst;

  assign rdata = (gnt && !w_oor) ? r_mem[w_idx] : '0;
  assign err   = gnt & w_oor;

  // Capture accepted request payload into the tail slot
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_addr[w_tail]  <= addr[XLEN-1:2];
      r_q_wstrb[w_tail] <= wstrb;
      r_q_wdata[w_tail] <= wdata;
    end
  end

  // Byte-lane write of the head entry on its grant edge
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < SW; i++) begin
        if (w_h_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_h_wdata[8*i +: 8];
        end
      end
    end
  end

  // Service FSM: occupancy, head pointer and latency counter
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_state <= S_IDLE;
      r_occ   <= 2'd0;
      r_head  <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (!nrst) begin
      r_state <= S_IDLE;
      r_occ   <= 2'd0;
      r_head  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_occ <= w_occ_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_WAIT;
            r_cnt   <= LAT4;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_cnt <= LAT4;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
          if (gnt) begin
            r_head <= ~r_head;
          end
          if (w_occ_nxt == 2'd0) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_mem_responder.sv
// Directed bench for ladybird_mem_responder.
// One instance at LATENCY=1, one at LATENCY=3.
module tb_ladybird_mem_responder;

  logic        clk = 1'b0;
  logic        anrst = 1'b0;
  logic        nrst = 1'b1;

  logic        req1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [3:0]  wstrb1 = '0;
  logic [31:0] wdata1 = '0;
  logic        ready1, gnt1, err1;
  logic [31:0] rdata1;

  logic        req3 = 1'b0;
  logic [31:0] addr3 = '0;
  logic [3:0]  wstrb3 = '0;
  logic [31:0] wdata3 = '0;
  logic        ready3, gnt3, err3;
  logic [31:0] rdata3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ladybird_mem_responder #(
    .XLEN(32), .DEPTH(1024), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .req(req1), .addr(addr1), .wstrb(wstrb1), .wdata(wdata1),
    .ready(ready1), .gnt(gnt1), .rdata(rdata1), .err(err1)
  );

  ladybird_mem_responder #(
    .XLEN(32), .DEPTH(1024), .LATENCY(3)
  ) u_dut3 (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .req(req3), .addr(addr3), .wstrb(wstrb3), .wdata(wdata3),
    .ready(ready3), .gnt(gnt3), .rdata(rdata3), .err(err3)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    bit          ck;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t tab [17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic txn1(input vec_t v, input int idx);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready", idx), ready1, 1);
    req1 = 1'b1; addr1 = v.a; wstrb1 = v.s; wdata1 = v.d;
    @(negedge clk);
    chk($sformatf("v%0d_gnt_early", idx), gnt1, 0);
    chk($sformatf("v%0d_rdata_idle", idx), rdata1, 0);
    chk($sformatf("v%0d_err_idle", idx), err1, 0);
    @(posedge clk); #1;
    req1 = 1'b0; wstrb1 = '0;
    chk($sformatf("v%0d_gnt", idx), gnt1, 1);
    if (v.ck) chk($sformatf("v%0d_rdata", idx), rdata1, v.rd);
    chk($sformatf("v%0d_err", idx), err1, v.e);
  endtask

  task automatic txn3(input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit ck,
                      input logic [31:0] rd, input string name);
    @(posedge clk); #1;
    chk({name, "_ready"}, ready3, 1);
    req3 = 1'b1; addr3 = a; wstrb3 = s; wdata3 = d;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req3 = 1'b0; wstrb3 = '0;
      end
      chk($sformatf("%s_gnt_c%0d", name, k), gnt3, (k == 3) ? 1 : 0);
    end
    if (ck) chk({name, "_rdata"}, rdata3, rd);
    chk({name, "_err"}, err3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{32'h10,       4'hF, 32'hDEADBEEF, 0, 32'h0,        0};
    tab[1]  = '{32'h10,       4'h0, 32'h0,        1, 32'hDEADBEEF, 0};
    tab[2]  = '{32'h13,       4'h0, 32'h0,        1, 32'hDEADBEEF, 0};
    tab[3]  = '{32'h20,       4'hF, 32'h11223344, 0, 32'h0,        0};
    tab[4]  = '{32'h20,       4'h2, 32'hAABBCCDD, 1, 32'h11223344, 0};
    tab[5]  = '{32'h20,       4'h0, 32'h0,        1, 32'h1122CC44, 0};
    tab[6]  = '{32'h20,       4'h9, 32'h99887766, 1, 32'h1122CC44, 0};
    tab[7]  = '{32'h20,       4'h0, 32'h0,        1, 32'h9922CC66, 0};
    tab[8]  = '{32'h0,        4'hF, 32'h0BADF00D, 0, 32'h0,        0};
    tab[9]  = '{32'hFFC,      4'hF, 32'hCAFEF00D, 0, 32'h0,        0};
    tab[10] = '{32'h1000,     4'hF, 32'h55555555, 1, 32'h0,        1};
    tab[11] = '{32'h1000,     4'h0, 32'h0,        1, 32'h0,        1};
    tab[12] = '{32'h80000010, 4'h0, 32'h0,        1, 32'h0,        1};
    tab[13] = '{32'h0,        4'h0, 32'h0,        1, 32'h0BADF00D, 0};
    tab[14] = '{32'hFFC,      4'h0, 32'h0,        1, 32'hCAFEF00D, 0};
    tab[15] = '{32'h30,       4'hF, 32'h0000AAAA, 0, 32'h0,        0};
    tab[16] = '{32'h10,       4'h0, 32'h0,        1, 32'hDEADBEEF, 0};

    // reset state
    #12;
    chk("rst_ready1", ready1, 1);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_ready3", ready3, 1);
    chk("rst_gnt3", gnt3, 0);
    @(negedge clk);
    anrst = 1'b1;

    // table vectors on LATENCY=1
    for (int i = 0; i < 17; i++) begin
      txn1(tab[i], i);
    end

    // write then read of the same word queued together
    @(posedge clk); #1;
    req1 = 1'b1; addr1 = 32'h30; wstrb1 = 4'hF; wdata1 = 32'h12345678;
    @(posedge clk); #1;
    chk("wr_rd_wgnt", gnt1, 1);
    chk("wr_rd_wold", rdata1, 32'h0000AAAA);
    chk("wr_rd_ready", ready1, 1);
    addr1 = 32'h30; wstrb1 = 4'h0; wdata1 = '0;
    @(posedge clk); #1;
    req1 = 1'b0;
    chk("wr_rd_gap", gnt1, 0);
    @(posedge clk); #1;
    chk("wr_rd_rgnt", gnt1, 1);
    chk("wr_rd_rnew", rdata1, 32'h12345678);
    @(posedge clk); #1;
    chk("wr_rd_done", gnt1, 0);

    // LATENCY=3 setup writes
    txn3(32'h0,  4'hF, 32'hA0A0A0A0, 0, 32'h0, "p0");
    txn3(32'h4,  4'hF, 32'hB4B4B4B4, 0, 32'h0, "p4");
    txn3(32'h8,  4'hF, 32'hC8C8C8C8, 0, 32'h0, "p8");
    txn3(32'h0,  4'h0, 32'h0, 1, 32'hA0A0A0A0, "r0");

    // back-to-back reads, third one dropped
    @(posedge clk); #1;
    chk("b2b_rdy_c0", ready3, 1);
    req3 = 1'b1; addr3 = 32'h0; wstrb3 = 4'h0;
    @(posedge clk); #1;
    chk("b2b_rdy_c1", ready3, 1);
    addr3 = 32'h4;
    @(posedge clk); #1;
    chk("b2b_rdy_c2", ready3, 0);
    addr3 = 32'h8;
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("b2b_gnt_c3", gnt3, 1);
    chk("b2b_rdata_c3", rdata3, 32'hA0A0A0A0);
    for (int k = 4; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_gnt_c%0d", k), gnt3, (k == 7) ? 1 : 0);
      if (k == 4) chk("b2b_rdy_c4", ready3, 1);
      if (k == 7) chk("b2b_rdata_c7", rdata3, 32'hB4B4B4B4);
    end

    // async reset with two requests queued
    txn3(32'h40, 4'hF, 32'h77777777, 0, 32'h0, "p40");
    @(posedge clk); #1;
    req3 = 1'b1; addr3 = 32'h40; wstrb3 = 4'hF; wdata3 = 32'h12121212;
    @(posedge clk); #1;
    addr3 = 32'h44; wstrb3 = 4'h0; wdata3 = '0;
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("ar_full", ready3, 0);
    #2 anrst = 1'b0;
    #1;
    chk("ar_gnt", gnt3, 0);
    chk("ar_ready", ready3, 1);
    chk("ar_rdata", rdata3, 0);
    @(negedge clk);
    anrst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ar_nognt_%0d", k), gnt3, 0);
    end
    txn3(32'h40, 4'h0, 32'h0, 1, 32'h77777777, "ar_rd");

    // sync reset discards a pending write
    txn3(32'h50, 4'hF, 32'h5A5A5A5A, 0, 32'h0, "p50");
    @(posedge clk); #1;
    req3 = 1'b1; addr3 = 32'h50; wstrb3 = 4'hF; wdata3 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req3 = 1'b0; wstrb3 = 4'h0;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    chk("sr_ready", ready3, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("sr_nognt_%0d", k), gnt3, 0);
      @(posedge clk); #1;
    end
    txn3(32'h50, 4'h0, 32'h0, 1, 32'h5A5A5A5A, "sr_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ladybird_mem_responder.md
LADYBIRD_MEM_RESPONDER -- requirements
Module: ladybird_mem_responder

Interface
REQ-001 Parameter: XLEN, default 32, data/address width in bits.
REQ-002 Parameter: DEPTH, default 1024, memory size in XLEN-bit words, power of two.
REQ-003 Parameter: LATENCY, default 1, cycles from a request becoming head to its response, legal range 1..15.
REQ-004 Port: clk  input  1  clock, all state updates on rising edge.
REQ-005 Port: anrst  input  1  reset, asynchronous, active-low.
REQ-006 Port: nrst  input  1  synchronous reset, active-low, same effect as anrst but sampled on clk.
REQ-007 Port: req  input  1  request valid from initiator.
REQ-008 Port: addr  input  XLEN  byte address; word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-009 Port: wstrb  input  XLEN/8  byte-lane write enables; all-zero = read.
REQ-010 Port: wdata  input  XLEN  write data.
REQ-011 Port: ready  output  1  request queue can accept this cycle.
REQ-012 Port: gnt  output  1  one-cycle response strobe (drives initiator data_gnt).
REQ-013 Port: rdata  output  XLEN  response data, valid only while gnt=1.
REQ-014 Port: err  output  1  response error flag, valid only while gnt=1.

Function
REQ-015 Request accepted in any cycle with req=1 and ready=1; req while ready=0 is ignored (no retry memory, no side effect).
REQ-016 Accepted addr, wstrb, wdata captured into a 2-entry in-order request queue; responses returned strictly in acceptance order.
REQ-017 ready = 1 when queue occupancy < 2, computed from registered occupancy only (no same-cycle pop pass-through).
REQ-018 Simultaneous accept and gnt-pop: occupancy unchanged.
REQ-019 Head timing: entry accepted into an empty queue becomes head in its accept cycle C; otherwise becomes head in the cycle after its predecessor's gnt.
REQ-020 gnt high for exactly one cycle, LATENCY cycles after the entry became head (C+LATENCY for an empty queue).
REQ-021 Two-state service FSM: IDLE (queue empty, gnt=0), WAIT (head present, down-counter running); WAIT->IDLE on gnt with no successor, WAIT->WAIT with counter reloaded to LATENCY when successor present.
REQ-022 Counter width 4 bits; loaded with LATENCY on head entry; gnt when counter reaches 1 and is then decremented; no wrap.
REQ-023 Read (wstrb=0): rdata = mem[index] as of the gnt cycle.
REQ-024 Write: at the gnt-cycle rising edge, byte lane i of mem[index] ← wdata[8i+7:8i] for each wstrb[i]=1; other lanes unchanged; rdata during gnt = pre-write word.
REQ-025 Read queued behind a write to the same word returns the written data.
REQ-026 Out-of-range: addr[XLEN-1:log2(DEPTH)+2] != 0 → err=1 with gnt, rdata=0, no memory write; timing unchanged.
REQ-027 rdata=0 and err=0 whenever gnt=0.

Reset
REQ-028 On anrst=0 (async) or nrst=0 (sync): queue emptied, FSM → IDLE, counter=0, gnt=0, err=0, rdata=0, ready=1.
REQ-029 Reset mid-operation: pending requests discarded with no response; any write not yet at its gnt edge is not applied.
REQ-030 Memory array not reset; contents undefined until written.
REQ-031 First request accepted in the first cycle after reset release.

Verification
REQ-032 LATENCY=1: write addr 0x10, wstrb 0xF, wdata 0xDEADBEEF at cycle C → gnt at C+1; read 0x10 next → rdata 0xDEADBEEF, err=0.
REQ-033 Byte lanes: word 0x20 = 0x11223344, write wstrb 0x2 wdata 0xAABBCCDD → subsequent read returns 0x1122CC44.
REQ-034 LATENCY=3, back-to-back reads at cycles C, C+1, C+2 → ready=0 in C+2 (third dropped), gnt at C+3 and C+7, in order.
REQ-035 Write then read of same word queued together → read rdata equals newly written word; write gnt rdata equals old word.
REQ-036 DEPTH=1024, read addr 0x1000 → gnt at C+LATENCY with err=1, rdata=0; write there leaves all words unchanged.
REQ-037 anrst pulsed low while two requests queued → gnt never asserted for them, ready=1 after release, queued write not visible on later read.
